// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared state encoding and constants for the RO PUF measurement stage
package ro_puf_pkg;
   typedef enum logic [1:0] {IDLE, MEASURE, COMPARE, DONE} ro_state_e;
   localparam int CNT_W_DEF = 16;
   localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/ro_puf_compare_edge_counter.sv
// ro_edge_counter: synchronizes one oscillator, detects rising edges and counts them with saturation
module ro_edge_counter import ro_puf_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ro,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             sat
);
   logic [SYNC_DEPTH-1:0] sync;
   logic prev;
   logic rise;
   assign rise = sync[SYNC_DEPTH-1] & ~prev;
   // synchronizer never stops so the first window cycle already sees a valid edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_DEPTH-2:0], ro};
         prev <= sync[SYNC_DEPTH-1];
      end
   end
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
         sat <= 1'b0;
      end else if (en && rise) begin
         if (&count) sat <= 1'b1;
         else count <= count + CNT_W'(1);
      end
   end
endmodule

// File: rtl/ro_puf_compare.sv
// ro_puf_compare: counts two ring-oscillator edges over a window and returns the comparison bit
module ro_puf_compare import ro_puf_pkg::*; #(
   parameter int WINDOW = 1024,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ro_a,
   input  logic             ro_b,
   input  logic             start,
   output logic             busy,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_bit,
   output logic             tie,
   output logic             sat,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b
);
   localparam int WW = $clog2(WINDOW + 1);
   localparam logic [WW-1:0] LAST = WW'(WINDOW - 1);
   ro_state_e state;
   logic [WW-1:0] win;
   logic [CNT_W-1:0] cnt_a, cnt_b;
   logic sat_a, sat_b, clr, en;
   assign clr = (state == IDLE) && start;
   assign en = (state == MEASURE);
   ro_edge_counter #(.CNT_W(CNT_W)) u_a (
      .clk(clk), .rst(rst), .ro(ro_a), .clr(clr), .en(en), .count(cnt_a), .sat(sat_a)
   );
   ro_edge_counter #(.CNT_W(CNT_W)) u_b (
      .clk(clk), .rst(rst), .ro(ro_b), .clr(clr), .en(en), .count(cnt_b), .sat(sat_b)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         win <= '0;
         busy <= 1'b0;
         resp_valid <= 1'b0;
         resp_bit <= 1'b0;
         tie <= 1'b0;
         sat <= 1'b0;
         count_a <= '0;
         count_b <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= MEASURE;
               win <= '0;
               busy <= 1'b1;
            end
            MEASURE: begin
               win <= win + WW'(1);
               if (win == LAST) state <= COMPARE;
            end
            COMPARE: begin
               state <= DONE;
               resp_valid <= 1'b1;
               resp_bit <= cnt_a > cnt_b;
               tie <= cnt_a == cnt_b;
               sat <= sat_a | sat_b;
               count_a <= cnt_a;
               count_b <= cnt_b;
            end
            DONE: if (resp_ready) begin
               state <= IDLE;
               busy <= 1'b0;
               resp_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
